pcsr_product_gen: RTL and testbench

PCSR_PRODUCT_GEN -- requirements
Module: pcsr_product_gen

---
 rtl/pcsr_product_gen.sv | 139 +++++++++++++
 tb/tb_pcsr_product_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcsr_product_gen.sv
// Scales each accepted pixel by every weight of a stored kernel row and emits the
// rounded products, one per cycle, toward the overlap-add stage.
//
// state | meaning
// EMPTY | no kernel held since reset
// LOAD  | kernel row partially written
// IDLE  | kernel complete, waiting for a pixel
// EMIT  | streaming the products of the latched pixel
module pcsr_product_gen #(
  parameter int BIT_WIDTH    = 8,
  parameter int INPUT_WIDTH  = 5,
  parameter int KERNEL_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 k_wr_en_i,
  input  logic [BIT_WIDTH-1:0] k_data_i,
  output logic                 k_loaded_o,
  input  logic                 pix_valid_i,
  input  logic [BIT_WIDTH-1:0] pix_data_i,
  output logic                 pix_ready_o,
  output logic [BIT_WIDTH-1:0] data_o,
  output logic                 wr_en_o,
  output logic                 last_o
);

  localparam int KW_W = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
  localparam int PC_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam logic [KW_W-1:0] K_LAST = KW_W'(KERNEL_WIDTH - 1);
  localparam logic [PC_W-1:0] P_LAST = PC_W'(INPUT_WIDTH - 1);

  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_IDLE, S_EMIT} state_t;

  state_t                 state_q, state_d;
  logic [BIT_WIDTH-1:0]   weight_q [KERNEL_WIDTH];
  logic [BIT_WIDTH-1:0]   weight_d [KERNEL_WIDTH];
  logic [KW_W-1:0]        k_cnt_q, k_cnt_d;
  logic [KW_W-1:0]        k_idx_q, k_idx_d;
  logic [PC_W-1:0]        pix_cnt_q, pix_cnt_d;
  logic [BIT_WIDTH-1:0]   pixel_q, pixel_d;
  logic [BIT_WIDTH-1:0]   data_q, data_d;
  logic                   wr_en_q, wr_en_d;
  logic                   last_q, last_d;

  logic [2*BIT_WIDTH-1:0] prod;
  logic [BIT_WIDTH-1:0]   prod_rnd;
  logic                   accept;
  logic                   unused_prod_lsbs;

  assign pix_ready_o = ((state_q == S_IDLE) && !k_wr_en_i) ||
                       ((state_q == S_EMIT) && (k_idx_q == K_LAST));
  assign accept      = pix_ready_o && pix_valid_i;
  assign k_loaded_o  = (state_q == S_IDLE) || (state_q == S_EMIT);

  // Round half up: the top half plus the MSB of the discarded half; cannot overflow.
  assign prod     = {{BIT_WIDTH{1'b0}}, pixel_q} * {{BIT_WIDTH{1'b0}}, weight_q[k_idx_q]};
  assign prod_rnd = prod[2*BIT_WIDTH-1:BIT_WIDTH] + {{(BIT_WIDTH-1){1'b0}}, prod[BIT_WIDTH-1]};
  assign unused_prod_lsbs = ^prod[BIT_WIDTH-2:0];

  assign data_o  = data_q;
  assign wr_en_o = wr_en_q;
  assign last_o  = last_q;

  always_comb begin
    state_d   = state_q;
    weight_d  = weight_q;
    k_cnt_d   = k_cnt_q;
    k_idx_d   = k_idx_q;
    pix_cnt_d = pix_cnt_q;
    pixel_d   = pixel_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    last_d    = 1'b0;

    case (state_q)
      S_EMPTY, S_IDLE: begin
        if (k_wr_en_i) begin
          weight_d[0] = k_data_i;
          k_cnt_d     = KW_W'(1);
          pix_cnt_d   = '0;
          state_d     = (KERNEL_WIDTH == 1) ? S_IDLE : S_LOAD;
        end else if (accept) begin
          pixel_d = pix_data_i;
          k_idx_d = '0;
          state_d = S_EMIT;
        end
      end
      S_LOAD: begin
        if (k_wr_en_i) begin
          weight_d[k_cnt_q] = k_data_i;
          k_cnt_d           = k_cnt_q + KW_W'(1);
          if (k_cnt_q == K_LAST) state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        data_d  = prod_rnd;
        wr_en_d = 1'b1;
        last_d  = (k_idx_q == K_LAST) && (pix_cnt_q == P_LAST);
        if (k_idx_q == K_LAST) begin
          pix_cnt_d = (pix_cnt_q == P_LAST) ? '0 : pix_cnt_q + PC_W'(1);
          if (accept) begin
            pixel_d = pix_data_i;
            k_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          k_idx_d = k_idx_q + KW_W'(1);
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_EMPTY;
      weight_q  <= '{default: '0};
      k_cnt_q   <= '0;
      k_idx_q   <= '0;
      pix_cnt_q <= '0;
      pixel_q   <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      weight_q  <= weight_d;
      k_cnt_q   <= k_cnt_d;
      k_idx_q   <= k_idx_d;
      pix_cnt_q <= pix_cnt_d;
      pixel_q   <= pixel_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_pcsr_product_gen.sv
// Directed bench for pcsr_product_gen: kernel load, product stream, arithmetic
// corners, row framing, write/pixel collision, writes during emission and reset abort.
module tb_pcsr_product_gen;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       k_wr_en_i;
  logic [7:0] k_data_i;
  logic       k_loaded_o;
  logic       pix_valid_i;
  logic [7:0] pix_data_i;
  logic       pix_ready_o;
  logic [7:0] data_o;
  logic       wr_en_o;
  logic       last_o;

  int passed = 0;
  int total  = 0;

  pcsr_product_gen #(.BIT_WIDTH(8), .INPUT_WIDTH(5), .KERNEL_WIDTH(5)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .k_wr_en_i   (k_wr_en_i),
    .k_data_i    (k_data_i),
    .k_loaded_o  (k_loaded_o),
    .pix_valid_i (pix_valid_i),
    .pix_data_i  (pix_data_i),
    .pix_ready_o (pix_ready_o),
    .data_o      (data_o),
    .wr_en_o     (wr_en_o),
    .last_o      (last_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference rounding: add half an LSB of the output, then truncate.
  function automatic int rnd(input int p, input int w);
    return (p * w + 128) >> 8;
  endfunction

  task automatic load_kernel(input logic [7:0] w [5]);
    for (int i = 0; i < 5; i++) begin
      k_wr_en_i = 1'b1;
      k_data_i  = w[i];
      step();
    end
    k_wr_en_i = 1'b0;
  endtask

  initial begin
    logic [7:0] w_a [5];
    logic [7:0] w_b [5];
    logic [7:0] w_c [5];
    logic [7:0] pix [5];
    logic [7:0] exp_a [5];
    logic [7:0] exp_c [5];
    int acc;
    int n;

    w_a   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd128};
    exp_a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd128};
    w_b   = '{8'd255, 8'd8, 8'd200, 8'd0, 8'd128};
    pix   = '{8'd255, 8'd16, 8'd100, 8'd0, 8'd200};
    w_c   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    exp_c = '{8'd4, 8'd2, 8'd3, 8'd5, 8'd6};

    rst_i = 1'b0; k_wr_en_i = 1'b0; k_data_i = '0; pix_valid_i = 1'b0; pix_data_i = '0;
    #3;
    chk("rst_data", data_o, 0);
    chk("rst_wr_en", wr_en_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_k_loaded", k_loaded_o, 0);
    chk("rst_ready", pix_ready_o, 0);
    step();
    @(negedge clk_i) rst_i = 1'b1;
    step();

    // Kernel 1,2,3,4,128 then pixel 255
    for (int i = 0; i < 5; i++) begin
      k_wr_en_i = 1'b1;
      k_data_i  = w_a[i];
      step();
      if (i < 4) begin
        chk("load_k_loaded", k_loaded_o, 0);
        chk("load_ready", pix_ready_o, 0);
      end
    end
    k_wr_en_i = 1'b0;
    #1;
    chk("loaded_flag", k_loaded_o, 1);
    chk("idle_ready", pix_ready_o, 1);
    pix_valid_i = 1'b1; pix_data_i = 8'd255;
    step();
    pix_valid_i = 1'b0;
    chk("accept_no_wr_yet", wr_en_o, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("basic_data", data_o, exp_a[k]);
      chk("basic_wr_en", wr_en_o, 1);
      chk("basic_last", last_o, 0);
      if (k == 0) chk("emit_ready_low", pix_ready_o, 0);
    end
    step();
    chk("after_wr_en", wr_en_o, 0);
    chk("after_hold", data_o, 128);

    // Corner products, back-to-back stream of a full row
    load_kernel(w_b);
    acc = 0;
    for (int c = 0; c <= 26; c++) begin
      pix_valid_i = (acc < 5);
      pix_data_i  = pix[acc % 5];
      #1;
      chk("stream_ready", pix_ready_o, (c == 26) ? 1 : ((c % 5) == 0));
      if ((c % 5) == 0 && c < 25) acc++;
      step();
      if (c >= 1 && c <= 25) begin
        n = c - 1;
        chk("stream_data", data_o, rnd(pix[n / 5], w_b[n % 5]));
        chk("stream_wr_en", wr_en_o, 1);
        chk("stream_last", last_o, (c == 25));
        if (c == 1)  chk("corner_255x255", data_o, 254);
        if (c == 7)  chk("corner_16x8", data_o, 1);
        if (c == 13) chk("corner_100x200", data_o, 78);
        if (c == 16) chk("corner_0xw", data_o, 0);
      end
      if (c == 26) begin
        chk("stream_end_wr_en", wr_en_o, 0);
        chk("stream_end_last", last_o, 0);
        chk("stream_end_hold", data_o, 100);
      end
    end
    pix_valid_i = 1'b0;

    // Kernel write and pixel together in IDLE: write wins
    k_wr_en_i = 1'b1; k_data_i = 8'd5; pix_valid_i = 1'b1; pix_data_i = 8'd99;
    #1;
    chk("collide_ready", pix_ready_o, 0);
    step();
    chk("collide_k_loaded", k_loaded_o, 0);
    chk("collide_no_emit", wr_en_o, 0);
    pix_valid_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      k_data_i = 8'(2 * i);
      step();
      if (i < 4) chk("reload_k_loaded", k_loaded_o, 0);
    end
    k_wr_en_i = 1'b0;
    #1;
    chk("reload_done", k_loaded_o, 1);
    chk("collide_no_late_emit", wr_en_o, 0);

    // Kernel writes during EMIT are ignored; two pixels of 200 with kernel 5,2,4,6,8
    for (int r = 0; r < 2; r++) begin
      pix_valid_i = 1'b1; pix_data_i = 8'd200;
      step();
      pix_valid_i = 1'b0;
      if (r == 0) begin
        k_wr_en_i = 1'b1; k_data_i = 8'd99;
      end
      for (int k = 0; k < 5; k++) begin
        step();
        chk("emitwr_data", data_o, exp_c[k]);
        chk("emitwr_wr_en", wr_en_o, 1);
      end
      k_wr_en_i = 1'b0;
      #1;
      chk("emitwr_k_loaded", k_loaded_o, 1);
    end

    // Reset in the middle of emission
    pix_valid_i = 1'b1; pix_data_i = 8'd255;
    step();
    pix_valid_i = 1'b0;
    step();
    step();
    chk("pre_rst_wr_en", wr_en_o, 1);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_data", data_o, 0);
    chk("midrst_wr_en", wr_en_o, 0);
    chk("midrst_last", last_o, 0);
    chk("midrst_k_loaded", k_loaded_o, 0);
    chk("midrst_ready", pix_ready_o, 0);
    @(negedge clk_i) rst_i = 1'b1;
    step();
    pix_valid_i = 1'b1; pix_data_i = 8'd255;
    #1;
    chk("postrst_ready", pix_ready_o, 0);
    for (int i = 0; i < 5; i++) begin
      k_wr_en_i = 1'b1;
      k_data_i  = w_c[i];
      step();
      if (i < 4) begin
        chk("postrst_load_ready", pix_ready_o, 0);
        chk("postrst_load_k_loaded", k_loaded_o, 0);
        chk("postrst_load_wr_en", wr_en_o, 0);
      end
    end
    k_wr_en_i = 1'b0;
    #1;
    chk("postrst_loaded", k_loaded_o, 1);
    chk("postrst_ready_up", pix_ready_o, 1);
    step();
    pix_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("postrst_data", data_o, k + 1);
      chk("postrst_wr_en", wr_en_o, 1);
      chk("postrst_last", last_o, 0);
    end
    step();
    chk("postrst_idle_wr_en", wr_en_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
